// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - loader state encoding and byte-to-word packing constants
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RECV,
    WRITE,
    RUN,
    ERR
  } loader_state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int BYTE_CNT_W     = $clog2(BYTES_PER_WORD);
  localparam int WORD_W         = 8 * BYTES_PER_WORD;

endpackage

// File: rtl/imem_boot_loader_if.sv
// rtl/imem_boot_loader_if.sv - byte stream and instruction-memory write port bundle
interface imem_boot_loader_if #(
  parameter int PC_SIZE = 10
);

  logic               byte_valid;
  logic [7:0]         byte_data;
  logic               byte_ready;
  logic               rw;
  logic [31:0]        instruction_in;
  logic [PC_SIZE-1:0] PC_write;
  logic               reset_IF_memory;

  // master is the loader; slave is the byte source plus instruction memory
  modport master (
    input  byte_valid,
    input  byte_data,
    output byte_ready,
    output rw,
    output instruction_in,
    output PC_write,
    output reset_IF_memory
  );

  modport slave (
    output byte_valid,
    output byte_data,
    input  byte_ready,
    input  rw,
    input  instruction_in,
    input  PC_write,
    input  reset_IF_memory
  );

endinterface

// File: rtl/byte_word_packer.sv
// rtl/byte_word_packer.sv - assembles little-endian bytes into 32-bit instruction words
module byte_word_packer
  import imem_loader_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              byte_accept,
  input  logic [7:0]        byte_data,
  output logic              word_valid,
  output logic [WORD_W-1:0] word
);

  logic [BYTE_CNT_W-1:0] byte_cnt;
  logic [WORD_W-1:0]     word_q;

  // word includes the byte being accepted now, so the writer can latch it on word_valid
  always_comb begin
    word = word_q;
    for (int k = 0; k < BYTES_PER_WORD; k++) begin
      if (byte_cnt == BYTE_CNT_W'(k)) begin
        word[8*k +: 8] = byte_data;
      end
    end
  end

  assign word_valid = byte_accept && (byte_cnt == BYTE_CNT_W'(BYTES_PER_WORD - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      byte_cnt <= '0;
      word_q   <= '0;
    end else if (clear) begin
      byte_cnt <= '0;
      word_q   <= '0;
    end else if (byte_accept) begin
      byte_cnt <= byte_cnt + BYTE_CNT_W'(1);
      word_q   <= word;
    end
  end

endmodule

// File: rtl/imem_boot_loader.sv
// rtl/imem_boot_loader.sv - boot-time instruction memory loader holding the core in reset until loaded
// LOADER_TIMEOUT_EN adds an idle-byte timeout in RECV that aborts the load to ERR.
module imem_boot_loader
  import imem_loader_pkg::*;
#(
  parameter int PC_SIZE = 10
`ifdef LOADER_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 1000000
`endif
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [PC_SIZE:0]    load_len,
  imem_boot_loader_if.master  bus,
  output logic                core_reset,
  output logic                busy,
  output logic                done,
  output logic                error
);

  localparam logic [PC_SIZE:0] MAX_LEN = {1'b1, {PC_SIZE{1'b0}}};
  localparam logic [PC_SIZE:0] LEN_ONE = (PC_SIZE + 1)'(1);

  loader_state_t      state;
  logic [PC_SIZE:0]   len_q;
  logic [PC_SIZE-1:0] word_idx;
  logic               byte_accept;
  logic               word_valid;
  logic               packer_clear;
  logic               last_word;
  logic               timed_out;
  logic [WORD_W-1:0]  packed_word;

  assign byte_accept  = bus.byte_valid && bus.byte_ready;
  assign packer_clear = (state == CLEAR) || (state == ERR);
  assign last_word    = ({1'b0, word_idx} == (len_q - LEN_ONE));

  byte_word_packer u_packer (
    .clock       (clock),
    .reset       (reset),
    .clear       (packer_clear),
    .byte_accept (byte_accept),
    .byte_data   (bus.byte_data),
    .word_valid  (word_valid),
    .word        (packed_word)
  );

`ifdef LOADER_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TW-1:0] idle_cnt;

  // held at zero outside RECV, so every entry into RECV starts a fresh count
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      idle_cnt <= '0;
    end else if ((state != RECV) || byte_accept) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + TW'(1);
    end
  end

  assign timed_out = (idle_cnt == TW'(TIMEOUT_CYCLES - 1)) && !byte_accept;
`else
  assign timed_out = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state               <= IDLE;
      len_q               <= '0;
      word_idx            <= '0;
      bus.rw              <= 1'b0;
      bus.instruction_in  <= '0;
      bus.PC_write        <= '0;
      bus.reset_IF_memory <= 1'b0;
      bus.byte_ready      <= 1'b0;
      core_reset          <= 1'b1;
      busy                <= 1'b0;
      done                <= 1'b0;
      error               <= 1'b0;
    end else begin
      bus.rw              <= 1'b0;
      bus.reset_IF_memory <= 1'b0;
      case (state)
        IDLE, RUN, ERR: begin
          if (start) begin
            len_q      <= load_len;
            word_idx   <= '0;
            core_reset <= 1'b1;
            done       <= 1'b0;
            if (load_len > MAX_LEN) begin
              state <= ERR;
              error <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state               <= CLEAR;
              error               <= 1'b0;
              busy                <= 1'b1;
              bus.reset_IF_memory <= 1'b1;
            end
          end
        end
        CLEAR: begin
          if (len_q == '0) begin
            state      <= RUN;
            core_reset <= 1'b0;
            done       <= 1'b1;
            busy       <= 1'b0;
          end else begin
            state          <= RECV;
            bus.byte_ready <= 1'b1;
          end
        end
        RECV: begin
          if (word_valid) begin
            state              <= WRITE;
            bus.byte_ready     <= 1'b0;
            bus.rw             <= 1'b1;
            bus.PC_write       <= word_idx;
            bus.instruction_in <= packed_word;
          end else if (timed_out) begin
            state          <= ERR;
            bus.byte_ready <= 1'b0;
            busy           <= 1'b0;
            error          <= 1'b1;
          end
        end
        WRITE: begin
          if (last_word) begin
            state      <= RUN;
            core_reset <= 1'b0;
            done       <= 1'b1;
            busy       <= 1'b0;
          end else begin
            state          <= RECV;
            word_idx       <= word_idx + PC_SIZE'(1);
            bus.byte_ready <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// tb/tb_imem_boot_loader.sv - table-driven and randomized self-checking bench for imem_boot_loader
module tb_imem_boot_loader;

  localparam int PC_SIZE  = 10;
  localparam int GAP_RAND = 99;

  typedef struct packed {
    int len;
    int gap;
    int mid_start;
    bit exp_error;
    bit exp_done;
    bit exp_core_reset;
  } vec_t;

  logic               clock = 1'b0;
  logic               reset;
  logic               start;
  logic [PC_SIZE:0]   load_len;
  logic               core_reset;
  logic               busy;
  logic               done;
  logic               error;

  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;

  imem_boot_loader_if #(.PC_SIZE(PC_SIZE)) bus ();

  imem_boot_loader #(
    .PC_SIZE(PC_SIZE)
`ifdef LOADER_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES(16)
`endif
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .load_len   (load_len),
    .bus        (bus),
    .core_reset (core_reset),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  int          wr_addr[$];
  logic [31:0] wr_data[$];
  int          wr_cyc[$];
  int          clr_cyc[$];
  int          ready_viol = 0;

  always @(negedge clock) begin
    if (bus.rw) begin
      wr_addr.push_back(int'(bus.PC_write));
      wr_data.push_back(bus.instruction_in);
      wr_cyc.push_back(cyc);
      if (bus.byte_ready) ready_viol <= ready_viol + 1;
    end
    if (bus.reset_IF_memory) clr_cyc.push_back(cyc);
  end

  logic [7:0] basic_bytes [8] = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
  logic [7:0] src_bytes[$];
  int         src_gaps[$];
  int         exp_acc[$];

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: actual %0d (0x%0h) required %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  // Byte j is accepted in the first cycle where it is offered and the loader is in RECV;
  // RECV opens two cycles after start and skips one WRITE cycle after every 4th byte.
  task automatic predict(input int s, input int nbytes);
    int prev, vs, ra;
    exp_acc.delete();
    prev = s;
    for (int j = 0; j < nbytes; j++) begin
      vs = prev + 1 + src_gaps[j];
      ra = (j == 0) ? s + 2 : (((j % 4) == 0) ? prev + 2 : prev + 1);
      prev = (vs > ra) ? vs : ra;
      exp_acc.push_back(prev);
    end
  endtask

  task automatic do_start(input int len, output int s);
    start    = 1'b1;
    load_len = (PC_SIZE + 1)'(len);
    @(negedge clock);
    s = cyc;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic feed(input int count, input int mid_start, output int last_acc);
    int j, gap_left, budget;
    j        = 0;
    budget   = 200 + count * 8;
    last_acc = -1;
    gap_left = (count > 0) ? src_gaps[0] : 0;
    while (j < count && budget > 0) begin
      bus.byte_valid = (gap_left == 0);
      bus.byte_data  = src_bytes[j];
      start          = (j == mid_start);
      load_len       = '0;
      @(negedge clock);
      if (bus.byte_valid && bus.byte_ready) begin
        last_acc = cyc;
        j++;
        if (j < count) gap_left = src_gaps[j];
      end else if (gap_left > 0) begin
        gap_left--;
      end
      @(posedge clock); #1;
      budget--;
    end
    bus.byte_valid = 1'b0;
    start          = 1'b0;
    if (j < count) chk("feed_bytes_accepted", j, count);
  endtask

  task automatic wait_status(input int limit, output int at);
    at = -1;
    for (int b = 0; b < limit && at < 0; b++) begin
      @(negedge clock);
      if (done || error) at = cyc;
      @(posedge clock); #1;
    end
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_rw"}, bus.rw, 0);
    chk({tag, "_instruction_in"}, bus.instruction_in, 0);
    chk({tag, "_PC_write"}, bus.PC_write, 0);
    chk({tag, "_reset_IF_memory"}, bus.reset_IF_memory, 0);
    chk({tag, "_byte_ready"}, bus.byte_ready, 0);
    chk({tag, "_core_reset"}, core_reset, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_error"}, error, 0);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int s, last, at, exp_status, nbytes, n_words, base_wr, base_clr, base_viol, n_wr;
    logic [31:0] exp_w;
    string tag;
    tag     = $sformatf("v%0d", idx);
    n_words = v.exp_error ? 0 : v.len;
    nbytes  = 4 * n_words;
    src_bytes.delete();
    src_gaps.delete();
    for (int j = 0; j < nbytes; j++) begin
      src_bytes.push_back((v.len == 2) ? basic_bytes[j] : 8'($urandom));
      src_gaps.push_back((v.gap == GAP_RAND) ? int'($urandom_range(3, 0)) : v.gap);
    end
    base_wr   = wr_addr.size();
    base_clr  = clr_cyc.size();
    base_viol = ready_viol;

    do_start(v.len, s);
    predict(s, nbytes);
    feed(nbytes, v.mid_start, last);
    wait_status(64, at);

    exp_status = v.exp_error ? s + 1 : ((nbytes == 0) ? s + 2 : exp_acc[nbytes-1] + 2);
    chk({tag, "_status_cycle"}, at, exp_status);
    if (nbytes > 0) chk({tag, "_last_accept_cycle"}, last, exp_acc[nbytes-1]);

    n_wr = wr_addr.size() - base_wr;
    chk({tag, "_write_count"}, n_wr, n_words);
    for (int k = 0; k < n_words && k < n_wr; k++) begin
      exp_w = 32'(src_bytes[4*k]) | (32'(src_bytes[4*k+1]) << 8) |
              (32'(src_bytes[4*k+2]) << 16) | (32'(src_bytes[4*k+3]) << 24);
      chk($sformatf("%s_wr%0d_addr", tag, k), wr_addr[base_wr+k], k);
      chk($sformatf("%s_wr%0d_data", tag, k), wr_data[base_wr+k], exp_w);
      chk($sformatf("%s_wr%0d_cycle", tag, k), wr_cyc[base_wr+k], exp_acc[4*k+3] + 1);
    end

    chk({tag, "_clear_pulses"}, clr_cyc.size() - base_clr, v.exp_error ? 0 : 1);
    if (clr_cyc.size() > base_clr) chk({tag, "_clear_cycle"}, clr_cyc[base_clr], s + 1);
    chk({tag, "_ready_during_write"}, ready_viol - base_viol, 0);

    repeat (2) @(posedge clock);
    @(negedge clock);
    chk({tag, "_done"}, done, v.exp_done);
    chk({tag, "_error"}, error, v.exp_error);
    chk({tag, "_core_reset"}, core_reset, v.exp_core_reset);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_byte_ready"}, bus.byte_ready, 0);
    chk({tag, "_rw_idle"}, bus.rw, 0);
    @(posedge clock); #1;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, required completion earlier");
    $fatal(1);
  end

  initial begin
    vec_t vecs [10];
    int   s, last, at, base;

    reset          = 1'b1;
    start          = 1'b0;
    load_len       = '0;
    bus.byte_valid = 1'b0;
    bus.byte_data  = '0;
    repeat (2) @(posedge clock);
    #1;
    check_reset_values("por");
    reset = 1'b0;
    @(posedge clock); #1;

    // len, gap, mid_start, exp_error, exp_done, exp_core_reset
    vecs[0] = '{2,        0,        -1, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{2,        3,        -1, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{0,        0,        -1, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{1025,     0,        -1, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{5,        GAP_RAND,  2, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{2047,     0,        -1, 1'b1, 1'b0, 1'b1};
    vecs[6] = '{1,        1,         0, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{1024,     0,        -1, 1'b0, 1'b1, 1'b0};
    vecs[8] = '{3,        GAP_RAND,  9, 1'b0, 1'b1, 1'b0};
    vecs[9] = '{1,        GAP_RAND, -1, 1'b0, 1'b1, 1'b0};

    for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

    // reset after six bytes of a three-word load: one word already written, outputs drop at once
    src_bytes.delete();
    src_gaps.delete();
    for (int j = 0; j < 12; j++) begin
      src_bytes.push_back(8'($urandom_range(255, 1)));
      src_gaps.push_back(0);
    end
    base = wr_addr.size();
    do_start(3, s);
    feed(6, -1, last);
    #2;
    reset = 1'b1;
    #1;
    check_reset_values("mid");
    chk("mid_writes_before_reset", wr_addr.size() - base, 1);
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;
    run_vec(vecs[0], 10);
    run_vec(vecs[4], 11);

`ifdef LOADER_TIMEOUT_EN
    src_bytes.delete();
    src_gaps.delete();
    for (int j = 0; j < 8; j++) begin
      src_bytes.push_back(8'($urandom));
      src_gaps.push_back(0);
    end
    base = wr_addr.size();
    do_start(2, s);
    feed(2, -1, last);
    wait_status(40, at);
    // accepting edge closes cycle last; error rises 16 edges later and is sampled one cycle on
    chk("to_error_cycle", at, last + 17);
    chk("to_error", error, 1);
    chk("to_writes", wr_addr.size() - base, 0);
    chk("to_core_reset", core_reset, 1);
    chk("to_busy", busy, 0);
    run_vec(vecs[1], 12);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
